hilo_muldiv: RTL and testbench

- Iterative multiply/divide unit with architectural HI/LO registers for the single-cycle MIPS datapath.
- Sits directly downstream of the register file and consumes its two read ports (rs and rt operand data).
- Executes MULT/MULTU/DIV/DIVU over multiple cycles behind a start/busy/done handshake, and MTHI/MTLO in one cycle.
- The control unit stalls the PC while busy=1; HI/LO feed the write-back mux for MFHI/MFLO.

---
 rtl/hilo_muldiv_if.sv | 25 ++
 rtl/hilo_muldiv.sv | 156 +++++++++++++++
 tb/tb_hilo_muldiv.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/hilo_muldiv_if.sv
// Handshake and operand/result bundle between the control/regfile side and
// the HI/LO multiply-divide unit.
interface hilo_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic             busy;
  logic             done;
  logic             dz;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, rs_data, rt_data,
    input  busy, done, dz, hi, lo
  );

  modport slave (
    input  start, op, rs_data, rt_data,
    output busy, done, dz, hi, lo
  );
endinterface

// File: rtl/hilo_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Signed ops run the unsigned core on magnitudes; signs are fixed up at the
// final RUN cycle, which is also the edge that writes HI/LO and raises done.
module hilo_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  hilo_muldiv_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hacc_q, hacc_d;   // mul: upper product / div: remainder
  logic [WIDTH-1:0] lacc_q, lacc_d;   // mul: multiplier/lower product / div: dividend->quotient
  logic [WIDTH-1:0] opnd_q, opnd_d;   // multiplicand or divisor magnitude
  logic             is_div_q, is_div_d;
  logic             neg_hi_q, neg_hi_d;
  logic             neg_lo_q, neg_lo_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  // Operand magnitudes: only signed ops (op[0]=0) look at the sign bit.
  logic             rs_neg, rt_neg;
  logic [WIDTH-1:0] rs_abs, rt_abs;
  assign rs_neg = ~bus.op[0] & bus.rs_data[WIDTH-1];
  assign rt_neg = ~bus.op[0] & bus.rt_data[WIDTH-1];
  assign rs_abs = rs_neg ? -bus.rs_data : bus.rs_data;
  assign rt_abs = rt_neg ? -bus.rt_data : bus.rt_data;

  // One shift-add step and one restoring-division step.
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift, div_diff;
  logic [2*WIDTH-1:0] prod_raw, prod_fix;
  assign mul_sum   = {1'b0, hacc_q} + (lacc_q[0] ? {1'b0, opnd_q} : '0);
  assign div_shift = {hacc_q, lacc_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opnd_q};
  assign prod_raw  = {hacc_q, lacc_q};
  assign prod_fix  = neg_lo_q ? -prod_raw : prod_raw;

  assign bus.busy = (state_q == S_RUN);
  assign bus.done = (state_q == S_DONE);
  assign bus.dz   = (state_q == S_DONE) & dz_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

  // Next-state, datapath iteration and HI/LO write selection.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hacc_d   = hacc_q;
    lacc_d   = lacc_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    neg_hi_d = neg_hi_q;
    neg_lo_d = neg_lo_q;
    dz_d     = dz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          case (bus.op)
            3'b000, 3'b001, 3'b010, 3'b011: begin
              state_d  = S_RUN;
              is_div_d = bus.op[1];
              neg_lo_d = rs_neg ^ rt_neg;
              neg_hi_d = bus.op[1] ? rs_neg : (rs_neg ^ rt_neg);
              hacc_d   = '0;
              if (bus.op[1]) begin
                lacc_d = rs_abs;
                opnd_d = rt_abs;
              end else begin
                lacc_d = rt_abs;
                opnd_d = rs_abs;
              end
              if (bus.op[1] && bus.rt_data == '0) begin
                // Skip the iterations: the next RUN cycle goes straight to DONE.
                dz_d  = 1'b1;
                cnt_d = CW'(WIDTH);
              end else begin
                dz_d  = 1'b0;
                cnt_d = '0;
              end
            end
            3'b100:  hi_d = bus.rs_data;
            3'b101:  lo_d = bus.rs_data;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        if (cnt_q == CW'(WIDTH)) begin
          state_d = S_DONE;
          if (!dz_q) begin
            if (is_div_q) begin
              lo_d = neg_lo_q ? -lacc_q : lacc_q;
              hi_d = neg_hi_q ? -hacc_q : hacc_q;
            end else begin
              hi_d = prod_fix[2*WIDTH-1:WIDTH];
              lo_d = prod_fix[WIDTH-1:0];
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (is_div_q) begin
            if (!div_diff[WIDTH]) begin
              hacc_d = div_diff[WIDTH-1:0];
              lacc_d = {lacc_q[WIDTH-2:0], 1'b1};
            end else begin
              hacc_d = div_shift[WIDTH-1:0];
              lacc_d = {lacc_q[WIDTH-2:0], 1'b0};
            end
          end else begin
            {hacc_d, lacc_d} = {mul_sum, lacc_q[WIDTH-1:1]};
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      hacc_q   <= '0;
      lacc_q   <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      neg_hi_q <= 1'b0;
      neg_lo_q <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hacc_q   <= hacc_d;
      lacc_q   <= lacc_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      neg_hi_q <= neg_hi_d;
      neg_lo_q <= neg_lo_d;
      dz_q     <= dz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end
endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed bench for hilo_muldiv: arithmetic results, latency, divide by
// zero, MTHI/MTLO, ignored starts and asynchronous reset mid-operation.
module tb_hilo_muldiv;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   lat;

  hilo_muldiv_if #(.WIDTH(32)) bus ();

  hilo_muldiv #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a start for exactly one rising edge (edge k), return just after it
  // with operands scrambled so latching is exercised.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.rs_data = a; bus.rt_data = b;
    @(negedge clk);
    bus.start = 1'b0; bus.rs_data = $urandom; bus.rt_data = $urandom;
  endtask

  // Cycles after edge k until done is seen; 60 means it never came.
  task automatic wait_done(output int n);
    n = 0;
    while (bus.done !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.op = 3'b000; bus.rs_data = '0; bus.rt_data = '0;

    // Reset state
    #12;
    chk("rst_hi", bus.hi, 0);
    chk("rst_lo", bus.lo, 0);
    chk("rst_busy_done_dz", {bus.busy, bus.done, bus.dz}, 0);
    rst = 1'b1;

    // 1: MULT -3 * 7
    issue(3'b000, 32'hFFFFFFFD, 32'h00000007);
    chk("t1_busy_after_start", bus.busy, 1);
    repeat (32) @(negedge clk);
    chk("t1_busy_last_run", {bus.busy, bus.done}, 2'b10);
    chk("t1_hi_held_in_run", bus.hi, 0);
    wait_done(lat);
    chk("t1_latency", lat, 1);
    chk("t1_hi", bus.hi, 32'hFFFFFFFF);
    chk("t1_lo", bus.lo, 32'hFFFFFFEB);
    chk("t1_dz_busy", {bus.dz, bus.busy}, 0);
    @(negedge clk);
    chk("t1_done_pulse", bus.done, 0);

    // 2: MULTU / MULT of all-ones
    issue(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(lat);
    chk("t2u_latency", lat, 33);
    chk("t2u_hilo", {bus.hi, bus.lo}, 64'hFFFFFFFE_00000001);
    issue(3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(lat);
    chk("t2s_hilo", {bus.hi, bus.lo}, 64'h00000000_00000001);

    // 3: signed divide, then overflow case
    issue(3'b010, 32'hFFFFFFF9, 32'h00000002);
    wait_done(lat);
    chk("t3_latency", lat, 33);
    chk("t3_hilo", {bus.hi, bus.lo}, 64'hFFFFFFFF_FFFFFFFD);
    chk("t3_dz", bus.dz, 0);
    issue(3'b010, 32'h80000000, 32'hFFFFFFFF);
    wait_done(lat);
    chk("t3_ovf_hilo", {bus.hi, bus.lo}, 64'h00000000_80000000);

    // 4: MTHI / MTLO then DIVU by zero
    issue(3'b100, 32'h00001234, 32'h0);
    chk("t4_mthi_hi", bus.hi, 32'h00001234);
    chk("t4_mthi_busy_done", {bus.busy, bus.done}, 0);
    issue(3'b101, 32'hDEADBEEF, 32'h0);
    chk("t4_mtlo_lo", bus.lo, 32'hDEADBEEF);
    chk("t4_mtlo_busy_done", {bus.busy, bus.done}, 0);
    @(negedge clk);
    chk("t4_mt_no_done", bus.done, 0);
    issue(3'b011, 32'h00000005, 32'h0);
    chk("t4_dz_not_early", bus.done, 0);
    wait_done(lat);
    chk("t4_dz_latency", lat, 1);
    chk("t4_dz_flag", bus.dz, 1);
    chk("t4_dz_hilo", {bus.hi, bus.lo}, 64'h00001234_DEADBEEF);

    // op 11x is a no-op
    issue(3'b110, 32'h55555555, 32'h1);
    chk("noop_state", {bus.busy, bus.done, bus.hi, bus.lo}, {2'b00, 64'h00001234_DEADBEEF});

    // 5: MULTU 3*5 with an MTLO during RUN and an MTHI during DONE
    issue(3'b001, 32'h3, 32'h5);
    repeat (9) @(negedge clk);
    bus.start = 1'b1; bus.op = 3'b101; bus.rs_data = 32'hAAAAAAAA;
    @(negedge clk);
    bus.start = 1'b0;
    chk("t5_mtlo_ignored", bus.lo, 32'hDEADBEEF);
    chk("t5_still_busy", bus.busy, 1);
    wait_done(lat);
    chk("t5_latency", lat + 10, 33);
    chk("t5_hilo", {bus.hi, bus.lo}, 64'h00000000_0000000F);
    bus.start = 1'b1; bus.op = 3'b100; bus.rs_data = 32'h55555555;
    @(negedge clk);
    bus.start = 1'b0;
    chk("t5_mthi_in_done_ignored", bus.hi, 0);

    // 6: reset mid-DIVU, then a clean DIVU 100/7
    issue(3'b011, 32'd100, 32'd7);
    repeat (11) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("t6_rst_hilo", {bus.hi, bus.lo}, 0);
    chk("t6_rst_busy_done", {bus.busy, bus.done}, 0);
    @(negedge clk);
    rst = 1'b1;
    issue(3'b011, 32'd100, 32'd7);
    wait_done(lat);
    chk("t6_latency", lat, 33);
    chk("t6_hilo", {bus.hi, bus.lo}, 64'h00000002_0000000E);
    chk("t6_dz", bus.dz, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
